// File: rtl/truth_table_sweeper.sv
// Exhaustive stimulus sweeper: steps vec through every input vector, waits a
// settle time, and records where two combinational functions disagree.
module truth_table_sweeper #(
  parameter int N_IN          = 3,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N_IN-1:0]      vec,
  input  logic                 f_a,
  input  logic                 f_b,
  output logic                 busy,
  output logic                 done,
  output logic                 equal,
  output logic [2**N_IN-1:0]   mismatch_mask,
  output logic [N_IN:0]        mismatch_count,
  output logic [N_IN-1:0]      first_mismatch,
  output logic                 first_valid
);

  // state  | meaning
  // IDLE   | waiting for start after reset
  // SETTLE | holding vec while the functions under test settle
  // SAMPLE | comparing f_a/f_b at the edge ending this cycle
  // DONE   | sweep finished, results held until start or reset
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [7:0]      SETTLE_LD  = 8'(SETTLE_CYCLES);
  localparam logic [1:0]      S_AFTER_LD = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
  localparam logic [N_IN-1:0] VEC_LAST   = '1;

  logic [1:0]  state;
  logic [7:0]  settle_cnt;
  logic        miss;
  logic [N_IN:0] count_next;

  assign miss       = f_a ^ f_b;
  assign count_next = mismatch_count + {{N_IN{1'b0}}, miss};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      vec            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      equal          <= 1'b0;
      mismatch_mask  <= '0;
      mismatch_count <= '0;
      first_mismatch <= '0;
      first_valid    <= 1'b0;
      settle_cnt     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec            <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            equal          <= 1'b0;
            mismatch_mask  <= '0;
            mismatch_count <= '0;
            first_mismatch <= '0;
            first_valid    <= 1'b0;
            settle_cnt     <= SETTLE_LD;
            state          <= S_AFTER_LD;
          end
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 8'd1;
          if (settle_cnt == 8'd1) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          if (miss) begin
            mismatch_mask[vec] <= 1'b1;
            mismatch_count     <= count_next;
            if (!first_valid) begin
              first_mismatch <= vec;
              first_valid    <= 1'b1;
            end
          end
          if (vec != VEC_LAST) begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_LD;
            state      <= S_AFTER_LD;
          end else begin
            // count_next already includes the final vector's comparison
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            equal <= (count_next == '0);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
